// File: rtl/result_seg_display.sv
// result_seg_display: captures a 16-bit result and time-multiplexes it onto a 4-digit common-anode display.
// Define SEG_DECIMAL_EN for decimal mode (double-dabble conversion); left undefined, digits are shown in hex.
module result_seg_display #(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic        Clk_100MHz,
    input  logic        Rst_n,
    input  logic [15:0] result,
    input  logic        result_valid,
    output logic        busy,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
`ifdef SEG_DECIMAL_EN
    localparam int DISP_W = 20;
`else
    localparam int DISP_W = 16;
`endif

    logic [DISP_W-1:0] disp;
    logic              overflow;
    logic [CNT_W-1:0]  refresh_cnt;
    logic [1:0]        digit_idx;
    logic [3:0]        digit;
    logic [15:0]       upper;
    logic [6:0]        seg_nxt;
    logic              dp_nxt;
    logic [3:0]        an_nxt;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'h0:    seg_code = 7'b1000000;
            4'h1:    seg_code = 7'b1111001;
            4'h2:    seg_code = 7'b0100100;
            4'h3:    seg_code = 7'b0110000;
            4'h4:    seg_code = 7'b0011001;
            4'h5:    seg_code = 7'b0010010;
            4'h6:    seg_code = 7'b0000010;
            4'h7:    seg_code = 7'b1111000;
            4'h8:    seg_code = 7'b0000000;
            4'h9:    seg_code = 7'b0010000;
            4'hA:    seg_code = 7'b0001000;
            4'hB:    seg_code = 7'b0000011;
            4'hC:    seg_code = 7'b1000110;
            4'hD:    seg_code = 7'b0100001;
            4'hE:    seg_code = 7'b0000110;
            default: seg_code = 7'b0001110;
        endcase
    endfunction

    // NOTE: state updates use <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge Clk_100MHz) begin
        if (!Rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // NOTE: every signal here is assigned on every path; a missed branch would infer a latch.
    always_comb begin
        digit  = disp[{digit_idx, 2'b00} +: 4];
        upper  = disp[15:0] >> {digit_idx, 2'b00};
        an_nxt = ~(4'b0001 << digit_idx);
        dp_nxt = ~(overflow && digit_idx == 2'd0);
        if (overflow)
            seg_nxt = 7'b0111111;
        else if (BLANK_LEADING != 0 && digit_idx != 2'd0 && upper == 16'h0)
            seg_nxt = 7'h7F;
        else
            seg_nxt = seg_code(digit);
    end

    always_ff @(posedge Clk_100MHz) begin
        if (!Rst_n) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
            an  <= 4'b1111;
        end else begin
            seg <= seg_nxt;
            dp  <= dp_nxt;
            an  <= an_nxt;
        end
    end

`ifdef SEG_DECIMAL_EN
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] bin_q;
    logic [19:0] bcd_q, bcd_adj;
    logic [3:0]  iter_q;
    logic        pend_valid;
    logic [15:0] pend_val;

    always_ff @(posedge Clk_100MHz) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend_valid || result_valid) state_nxt = SHIFT;
            SHIFT:   if (iter_q == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A queued value keeps busy asserted through the IDLE cycle between back-to-back conversions.
    always_comb busy = (state != IDLE) || pend_valid;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // IDLE drains the pending slot first; a strobe in that same cycle refills it (last value wins).
    always_ff @(posedge Clk_100MHz) begin
        if (!Rst_n) begin
            pend_valid <= 1'b0;
            pend_val   <= '0;
        end else if (result_valid) begin
            if (state != IDLE || pend_valid) begin
                pend_valid <= 1'b1;
                pend_val   <= result;
            end
        end else if (state == IDLE) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk_100MHz) begin
        if (!Rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            disp   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    iter_q <= '0;
                    bcd_q  <= '0;
                    if (pend_valid)        bin_q <= pend_val;
                    else if (result_valid) bin_q <= result;
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    iter_q         <= iter_q + 4'd1;
                end
                DONE:    disp <= bcd_q;
                default: ;
            endcase
        end
    end

    always_comb overflow = (disp[19:16] != 4'h0);
`else
    always_comb busy     = 1'b0;
    always_comb overflow = 1'b0;

    always_ff @(posedge Clk_100MHz) begin
        if (!Rst_n)            disp <= '0;
        else if (result_valid) disp <= result;
    end
`endif

endmodule
